// File: rtl/dcache_wb_assoc_if.sv
// Pipeline request/response and main-memory line transfer signals of the data cache.
// The master modport is the pipeline/memory side, the slave modport is the cache.
interface dcache_wb_assoc_if #(
  parameter int ADDR_W         = 32,
  parameter int WORD_W         = 32,
  parameter int WORDS_PER_LINE = 4
);
  localparam int LINE_W = WORD_W * WORDS_PER_LINE;
  localparam int MA_W   = ADDR_W - $clog2(LINE_W / 8);

  logic              req_valid;
  logic              req_we;
  logic              req_byte;
  logic [ADDR_W-1:0] req_addr;
  logic [WORD_W-1:0] req_wdata;
  logic              resp_valid;
  logic [WORD_W-1:0] resp_rdata;
  logic              stall;
  logic              mem_rd;
  logic              mem_wr;
  logic [MA_W-1:0]   mem_addr;
  logic [LINE_W-1:0] mem_wline;
  logic [LINE_W-1:0] mem_rline;
  logic              mem_ready;

  modport master (
    output req_valid, req_we, req_byte, req_addr, req_wdata, mem_rline, mem_ready,
    input  resp_valid, resp_rdata, stall, mem_rd, mem_wr, mem_addr, mem_wline
  );

  modport slave (
    input  req_valid, req_we, req_byte, req_addr, req_wdata, mem_rline, mem_ready,
    output resp_valid, resp_rdata, stall, mem_rd, mem_wr, mem_addr, mem_wline
  );
endinterface

// File: rtl/dcache_wb_assoc.sv
// Set-associative write-back, write-allocate data cache with round-robin replacement.
// Misses write back a dirty victim, refill the line, then replay the held request as a hit.
module dcache_wb_assoc #(
  parameter int ADDR_W         = 32,
  parameter int WORD_W         = 32,
  parameter int NUM_SETS       = 4,
  parameter int NUM_WAYS       = 2,
  parameter int WORDS_PER_LINE = 4
) (
  input logic              clk,
  input logic              rst,
  dcache_wb_assoc_if.slave bus
);
  localparam int LINE_W = WORD_W * WORDS_PER_LINE;
  localparam int BYTES  = WORD_W / 8;
  localparam int BO_W   = $clog2(BYTES);
  localparam int WO_W   = $clog2(WORDS_PER_LINE);
  localparam int IDX_W  = $clog2(NUM_SETS);
  localparam int TAG_W  = ADDR_W - BO_W - WO_W - IDX_W;
  localparam int MA_W   = ADDR_W - BO_W - WO_W;
  localparam int WAY_W  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

  typedef enum logic [1:0] {IDLE, WB, REFILL} state_t;
  state_t state_reg;

  logic              valid_reg [NUM_WAYS][NUM_SETS];
  logic              dirty_reg [NUM_WAYS][NUM_SETS];
  logic [WAY_W-1:0]  ptr_reg   [NUM_SETS];
  logic [TAG_W-1:0]  tag_mem   [NUM_WAYS][NUM_SETS];
  logic [LINE_W-1:0] data_mem  [NUM_WAYS][NUM_SETS];

  logic              resp_valid_reg;
  logic [WORD_W-1:0] resp_rdata_reg;
  logic              mem_rd_reg;
  logic              mem_wr_reg;
  logic [MA_W-1:0]   mem_addr_reg;
  logic [LINE_W-1:0] mem_wline_reg;
  logic [WAY_W-1:0]  victim_reg;
  logic [IDX_W-1:0]  miss_idx_reg;
  logic [TAG_W-1:0]  miss_tag_reg;

  logic [BO_W-1:0]  boff;
  logic [WO_W-1:0]  woff;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  assign boff = bus.req_addr[BO_W-1:0];
  assign woff = bus.req_addr[BO_W +: WO_W];
  assign idx  = bus.req_addr[BO_W+WO_W +: IDX_W];
  assign tag  = bus.req_addr[ADDR_W-1 -: TAG_W];

  logic [NUM_WAYS-1:0] hit_vec;
  logic                hit;
  genvar gi, gj;
  generate
    for (gi = 0; gi < NUM_WAYS; gi++) begin : g_way
      assign hit_vec[gi] = valid_reg[gi][idx] && (tag_mem[gi][idx] == tag);
    end
  endgenerate
  assign hit = |hit_vec;

  // Descending scan so the lowest-numbered invalid way wins over the pointer.
  logic [WAY_W-1:0] hit_way;
  logic [WAY_W-1:0] victim_way;
  always_comb begin
    hit_way    = '0;
    victim_way = ptr_reg[idx];
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (hit_vec[w]) hit_way = WAY_W'(w);
      if (!valid_reg[w][idx]) victim_way = WAY_W'(w);
    end
  end

  logic [LINE_W-1:0] hit_line;
  logic [LINE_W-1:0] store_line;
  logic [WORD_W-1:0] hit_words [WORDS_PER_LINE];
  assign hit_line = data_mem[hit_way][idx];

  generate
    for (gi = 0; gi < WORDS_PER_LINE; gi++) begin : g_word
      assign hit_words[gi] = hit_line[gi*WORD_W +: WORD_W];
      for (gj = 0; gj < BYTES; gj++) begin : g_lane
        logic lane_we;
        assign lane_we = (woff == WO_W'(gi)) && (!bus.req_byte || (boff == BO_W'(gj)));
        assign store_line[gi*WORD_W + gj*8 +: 8] = !lane_we ? hit_line[gi*WORD_W + gj*8 +: 8] :
                                                   bus.req_byte ? bus.req_wdata[7:0] :
                                                   bus.req_wdata[gj*8 +: 8];
      end
    end
  endgenerate

  logic [WORD_W-1:0] load_word;
  logic [WORD_W-1:0] load_data;
  logic [7:0]        load_byte;
  assign load_word = hit_words[woff];
  assign load_byte = load_word[{boff, 3'b000} +: 8];
  assign load_data = bus.req_byte ? {{(WORD_W-8){1'b0}}, load_byte} : load_word;

  logic idle_access;
  assign idle_access = (state_reg == IDLE) && bus.req_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      resp_valid_reg <= 1'b0;
      resp_rdata_reg <= '0;
      mem_rd_reg     <= 1'b0;
      mem_wr_reg     <= 1'b0;
      mem_addr_reg   <= '0;
      mem_wline_reg  <= '0;
      victim_reg     <= '0;
      miss_idx_reg   <= '0;
      miss_tag_reg   <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        ptr_reg[s] <= '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
          valid_reg[w][s] <= 1'b0;
          dirty_reg[w][s] <= 1'b0;
        end
      end
    end else begin
      resp_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (idle_access && hit) begin
            resp_valid_reg <= 1'b1;
            if (bus.req_we) dirty_reg[hit_way][idx] <= 1'b1;
            else            resp_rdata_reg <= load_data;
          end else if (idle_access) begin
            victim_reg   <= victim_way;
            miss_idx_reg <= idx;
            miss_tag_reg <= tag;
            if (valid_reg[victim_way][idx] && dirty_reg[victim_way][idx]) begin
              state_reg     <= WB;
              mem_wr_reg    <= 1'b1;
              mem_addr_reg  <= {tag_mem[victim_way][idx], idx};
              mem_wline_reg <= data_mem[victim_way][idx];
            end else begin
              state_reg    <= REFILL;
              mem_rd_reg   <= 1'b1;
              mem_addr_reg <= {tag, idx};
            end
          end
        end
        WB: begin
          if (bus.mem_ready) begin
            state_reg                            <= REFILL;
            mem_wr_reg                           <= 1'b0;
            mem_rd_reg                           <= 1'b1;
            mem_addr_reg                         <= {miss_tag_reg, miss_idx_reg};
            dirty_reg[victim_reg][miss_idx_reg]  <= 1'b0;
          end
        end
        REFILL: begin
          if (bus.mem_ready) begin
            state_reg                           <= IDLE;
            mem_rd_reg                          <= 1'b0;
            valid_reg[victim_reg][miss_idx_reg] <= 1'b1;
            dirty_reg[victim_reg][miss_idx_reg] <= 1'b0;
            ptr_reg[miss_idx_reg] <= (ptr_reg[miss_idx_reg] == WAY_W'(NUM_WAYS - 1)) ?
                                     '0 : ptr_reg[miss_idx_reg] + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Tag and data arrays carry no reset; validity alone qualifies their contents.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (idle_access && hit && bus.req_we) begin
        data_mem[hit_way][idx] <= store_line;
      end else if (state_reg == REFILL && bus.mem_ready) begin
        data_mem[victim_reg][miss_idx_reg] <= bus.mem_rline;
        tag_mem[victim_reg][miss_idx_reg]  <= miss_tag_reg;
      end
    end
  end

  assign bus.stall      = (state_reg != IDLE) || (bus.req_valid && !hit);
  assign bus.resp_valid = resp_valid_reg;
  assign bus.resp_rdata = resp_rdata_reg;
  assign bus.mem_rd     = mem_rd_reg;
  assign bus.mem_wr     = mem_wr_reg;
  assign bus.mem_addr   = mem_addr_reg;
  assign bus.mem_wline  = mem_wline_reg;
endmodule

// File: tb/tb_dcache_wb_assoc.sv
// Directed bench for dcache_wb_assoc: cold miss, hits, byte lanes, dirty eviction,
// delayed refill and reset during refill, each step checked against hand-computed values.
module tb_dcache_wb_assoc;
  logic clk = 1'b0;
  logic rst;
  int   tests  = 0;
  int   failed = 0;
  int   resp_count;

  dcache_wb_assoc_if #(.ADDR_W(32), .WORD_W(32), .WORDS_PER_LINE(4)) bus ();

  dcache_wb_assoc #(
    .ADDR_W(32), .WORD_W(32), .NUM_SETS(4), .NUM_WAYS(2), .WORDS_PER_LINE(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("[TB] %s observed %h expected %h", tag, obs, exp);
  endtask

  task automatic drive_req(input logic we, input logic is_byte, input logic [31:0] addr,
                           input logic [31:0] wdata);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_byte  = is_byte;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
  endtask

  // One-cycle mem_ready pulse carrying line data.
  task automatic mem_done(input logic [127:0] line);
    bus.mem_rline = line;
    bus.mem_ready = 1'b1;
    tick();
    bus.mem_ready = 1'b0;
  endtask

  localparam logic [127:0] LINE_A = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
  localparam logic [127:0] LINE_B = 128'hBBBB_0003_BBBB_0002_BBBB_0001_BBBB_0000;
  localparam logic [127:0] LINE_C = 128'hCCCC_0003_CCCC_0002_CCCC_0001_CCCC_0000;
  localparam logic [127:0] LINE_D = 128'h4444_4444_3333_3333_DEAD_5AEF_1111_1111;
  localparam logic [127:0] LINE_E = 128'hEEEE_0003_EEEE_0002_EEEE_0001_EEEE_0000;
  localparam logic [127:0] LINE_F = 128'hF0F0_0003_F0F0_0002_F0F0_0001_F0F0_0000;

  initial begin
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_byte  = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.mem_rline = '0;
    bus.mem_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("reset_resp_rdata", bus.resp_rdata, 32'd0);
    chk("reset_mem_rd", 32'(bus.mem_rd), 32'd0);
    chk("reset_mem_wr", 32'(bus.mem_wr), 32'd0);
    chk("reset_stall", 32'(bus.stall), 32'd0);

    // Stray mem_ready while idle must do nothing.
    bus.mem_ready = 1'b1;
    tick();
    bus.mem_ready = 1'b0;
    chk("idle_ready_mem_rd", 32'(bus.mem_rd), 32'd0);
    chk("idle_ready_resp", 32'(bus.resp_valid), 32'd0);

    // 1. Cold load 0x40.
    drive_req(1'b0, 1'b0, 32'h40, 32'h0);
    #1;
    chk("cold_stall", 32'(bus.stall), 32'd1);
    tick();
    chk("cold_mem_rd", 32'(bus.mem_rd), 32'd1);
    chk("cold_mem_wr", 32'(bus.mem_wr), 32'd0);
    chk("cold_mem_addr", 32'(bus.mem_addr), 32'h4);
    mem_done(LINE_A);
    chk("cold_refill_rd_low", 32'(bus.mem_rd), 32'd0);
    chk("cold_back_idle_stall", 32'(bus.stall), 32'd0);
    chk("cold_no_early_resp", 32'(bus.resp_valid), 32'd0);
    tick();
    chk("cold_resp_valid", 32'(bus.resp_valid), 32'd1);
    chk("cold_rdata", bus.resp_rdata, 32'h1111_1111);
    drive_req(1'b0, 1'b0, 32'h48, 32'h0);
    #1;
    chk("hit48_stall", 32'(bus.stall), 32'd0);
    tick();
    chk("hit48_resp_valid", 32'(bus.resp_valid), 32'd1);
    chk("hit48_rdata", bus.resp_rdata, 32'h3333_3333);
    chk("hit48_no_mem_rd", 32'(bus.mem_rd), 32'd0);

    // 2. Word store hit then load back.
    drive_req(1'b1, 1'b0, 32'h44, 32'hDEAD_BEEF);
    #1;
    chk("st44_stall", 32'(bus.stall), 32'd0);
    tick();
    chk("st44_resp_valid", 32'(bus.resp_valid), 32'd1);
    chk("st44_rdata_kept", bus.resp_rdata, 32'h3333_3333);
    drive_req(1'b0, 1'b0, 32'h44, 32'h0);
    tick();
    chk("ld44_rdata", bus.resp_rdata, 32'hDEAD_BEEF);

    // 3. Byte store to lane 1, then word and byte loads.
    drive_req(1'b1, 1'b1, 32'h45, 32'h0000_005A);
    tick();
    chk("stb45_resp_valid", 32'(bus.resp_valid), 32'd1);
    drive_req(1'b0, 1'b0, 32'h44, 32'h0);
    tick();
    chk("ld44_after_byte", bus.resp_rdata, 32'hDEAD_5AEF);
    drive_req(1'b0, 1'b1, 32'h45, 32'h0);
    tick();
    chk("ldb45_rdata", bus.resp_rdata, 32'h0000_005A);

    // 4. Fill way 1, then evict the dirty 0x40 line.
    drive_req(1'b0, 1'b0, 32'h140, 32'h0);
    tick();
    chk("ld140_mem_addr", 32'(bus.mem_addr), 32'h14);
    chk("ld140_mem_wr", 32'(bus.mem_wr), 32'd0);
    mem_done(LINE_B);
    tick();
    chk("ld140_rdata", bus.resp_rdata, 32'hBBBB_0000);
    drive_req(1'b0, 1'b0, 32'h240, 32'h0);
    tick();
    chk("ev_mem_wr", 32'(bus.mem_wr), 32'd1);
    chk("ev_mem_rd", 32'(bus.mem_rd), 32'd0);
    chk("ev_mem_addr", 32'(bus.mem_addr), 32'h004);
    chk("ev_wline_w1", bus.mem_wline[63:32], 32'hDEAD_5AEF);
    chk("ev_wline_w0", bus.mem_wline[31:0], 32'h1111_1111);
    mem_done(128'h0);
    chk("ev_wr_low", 32'(bus.mem_wr), 32'd0);
    chk("ev_refill_rd", 32'(bus.mem_rd), 32'd1);
    chk("ev_refill_addr", 32'(bus.mem_addr), 32'h024);
    mem_done(LINE_C);
    tick();
    chk("ld240_rdata", bus.resp_rdata, 32'hCCCC_0000);
    drive_req(1'b0, 1'b0, 32'h44, 32'h0);
    #1;
    chk("ld44_miss_stall", 32'(bus.stall), 32'd1);
    tick();
    chk("ld44_miss_rd", 32'(bus.mem_rd), 32'd1);
    chk("ld44_miss_wr", 32'(bus.mem_wr), 32'd0);

    // 5. Hold mem_ready low for 6 cycles during this refill.
    resp_count = 0;
    for (int i = 0; i < 6; i++) begin
      chk("wait_stall", 32'(bus.stall), 32'd1);
      chk("wait_mem_rd", 32'(bus.mem_rd), 32'd1);
      chk("wait_mem_addr", 32'(bus.mem_addr), 32'h004);
      if (bus.resp_valid) resp_count++;
      tick();
    end
    mem_done(LINE_D);
    for (int i = 0; i < 3; i++) begin
      if (bus.resp_valid) begin
        resp_count++;
        chk("slow_rdata", bus.resp_rdata, 32'hDEAD_5AEF);
        bus.req_valid = 1'b0;
      end
      tick();
    end
    chk("slow_resp_count", 32'(resp_count), 32'd1);

    // 6. Reset during a refill of 0x90.
    drive_req(1'b0, 1'b0, 32'h90, 32'h0);
    tick();
    chk("pre_rst_mem_rd", 32'(bus.mem_rd), 32'd1);
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    tick();
    rst = 1'b0;
    chk("rst_mem_rd", 32'(bus.mem_rd), 32'd0);
    chk("rst_stall", 32'(bus.stall), 32'd0);
    bus.mem_rline = LINE_E;
    bus.mem_ready = 1'b1;
    tick();
    bus.mem_ready = 1'b0;
    chk("late_ready_rd", 32'(bus.mem_rd), 32'd0);
    chk("late_ready_resp", 32'(bus.resp_valid), 32'd0);
    drive_req(1'b0, 1'b0, 32'h40, 32'h0);
    #1;
    chk("post_rst_stall", 32'(bus.stall), 32'd1);
    tick();
    chk("post_rst_mem_rd", 32'(bus.mem_rd), 32'd1);
    chk("post_rst_mem_addr", 32'(bus.mem_addr), 32'h004);
    mem_done(LINE_F);
    tick();
    chk("post_rst_resp", 32'(bus.resp_valid), 32'd1);
    chk("post_rst_rdata", bus.resp_rdata, 32'hF0F0_0000);
    bus.req_valid = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/dcache_wb_assoc.md
Name: dcache_wb_assoc

Overview:
Parametrised set-associative, write-back, write-allocate data cache. It replaces the direct-mapped write-through-on-conflict data cache in the memory stage. It serves word and byte loads and stores from the pipeline and stalls it on misses. Full lines are exchanged with main memory through a level req/ready handshake.

Parameters:
ADDR_W, 32, byte-address width
WORD_W, 32, data word width (fixed multiple of 8)
NUM_SETS, 4, number of sets (power of two, >=2)
NUM_WAYS, 2, associativity (power of two, >=1)
WORDS_PER_LINE, 4, words per line (power of two); LINE_W = WORD_W*WORDS_PER_LINE

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  access request; held stable by requester while stall=1
req_we  in  1  1=store, 0=load
req_byte  in  1  1=byte access, 0=word access
req_addr  in  ADDR_W  byte address
req_wdata  in  WORD_W  store data; byte stores use [7:0]
resp_valid  out  1  one-cycle pulse: access completed
resp_rdata  out  WORD_W  load data, valid with resp_valid
stall  out  1  pipeline stall (combinational)
mem_rd  out  1  line refill request
mem_wr  out  1  line write-back request
mem_addr  out  ADDR_W-log2(LINE_W/8)  line address
mem_wline  out  LINE_W  victim line data
mem_rline  in  LINE_W  refill data, valid with mem_ready
mem_ready  in  1  one-cycle pulse: memory transaction done

Behaviour:
- Address split, LSB first: byte offset (log2(WORD_W/8)), word offset (log2 WORDS_PER_LINE), index (log2 NUM_SETS), tag (remaining bits).
- Per way and set: valid, dirty, tag, data. Per set: round-robin victim pointer.
- Reset: all valid=0, dirty=0, pointers=0, state=IDLE, mem_rd=0, mem_wr=0, resp_valid=0, resp_rdata=0. Data/tag arrays are not reset.
- Reset mid-transaction: any outstanding memory request is abandoned. mem_rd/mem_wr are 0 in the cycle after rst. A late mem_ready is ignored.
- Hit: a way in the indexed set has valid=1 and a matching tag. Multiple hits cannot occur.
- stall = (state!=IDLE) | (req_valid & !hit).
- States:
  - IDLE, hit load: resp_valid=1 and resp_rdata registered on the next edge (1-cycle latency). Word load returns the addressed word. Byte load returns the zero-extended byte selected by the byte offset.
  - IDLE, hit store: the word, or the single byte lane, is written at the edge; dirty=1; resp_valid=1 next cycle; resp_rdata unchanged.
  - IDLE, miss, victim valid & dirty: go to WB. Register mem_wr=1, mem_addr={victim tag,index}, mem_wline=victim data.
  - IDLE, miss, otherwise: go to REFILL. Register mem_rd=1, mem_addr={req tag,index}.
  - WB: outputs held stable until mem_ready. On mem_ready: mem_wr=0, dirty=0, then go to REFILL with mem_rd=1 next cycle.
  - REFILL: outputs held until mem_ready. On mem_ready: install mem_rline into the victim way (word 0 = bits [WORD_W-1:0]), valid=1, dirty=0, tag written, set pointer incremented modulo NUM_WAYS, mem_rd=0, go to IDLE.
- Back in IDLE, the held request hits and completes as above. Miss latency = WB wait + refill wait + 1.
- Victim choice: first invalid way (lowest index), else the set pointer.
- mem_rd and mem_wr are never high together. mem_ready outside WB/REFILL is ignored.
- If req_valid drops during WB/REFILL, the refill still completes and no resp_valid is produced.
- A store miss allocates the line first, then writes in IDLE.
- No response while stall=1. Only one access is outstanding at a time.

Test Plan:
All scenarios use default parameters: index=addr[5:4], tag=addr[31:6], mem_addr=addr[31:4].
1. Cold load 0x40 → stall=1. mem_rd=1 with mem_addr=0x4. After mem_ready with rline=0x4444_4444_3333_3333_2222_2222_1111_1111, resp_valid=1 with rdata=0x11111111 one cycle after returning to IDLE. Then load 0x48 → 0x33333333, no memory traffic.
2. Store 0x44 word 0xDEADBEEF (hit) → no stall; load 0x44 → 0xDEADBEEF.
3. Byte store 0x45 data 0x5A → load 0x44 returns 0xDEAD5AEF; byte load 0x45 returns 0x0000005A.
4. Loads 0x140 then 0x240 (set 0 full: dirty 0x40 line in way 0, 0x140 in way 1) → mem_wr=1 with mem_addr=0x004 and mem_wline containing 0xDEAD5AEF in word 1. Then mem_rd with mem_addr=0x024. A later load of 0x44 misses.
5. mem_ready delayed 6 cycles during REFILL → stall, mem_rd and mem_addr all stable for 6 cycles. Exactly one resp_valid.
6. rst asserted during REFILL → next cycle mem_rd=0, stall=0 with req_valid=0. The following load 0x40 misses (mem_rd reissued).
